// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
// Holds the default pattern constants and the overlap-mode encoding
// used by the detector and its configuration logic.
package seq_det_pkg;

  // Commonly used default patterns (MSB is the oldest bit).
  localparam logic [3:0] PAT_1010 = 4'b1010;
  localparam logic [3:0] PAT_1101 = 4'b1101;

  // Overlap mode: in NON_OVERLAP a match consumes its bits, so the next
  // match needs a full fresh pattern worth of valid bits.
  typedef enum logic {
    NON_OVERLAP = 1'b0,
    OVERLAP     = 1'b1
  } ovl_mode_e;

endpackage

// File: rtl/seq_det_if.sv
// Signal bundle between a serial lane / configuration master and the
// pattern detector.
//   master : drives x_valid, x, cfg_load, cfg_pattern, cfg_overlap,
//            cnt_clr; receives z_early, z, match_cnt.
//   slave  : the detector side (directions reversed).
interface seq_det_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
);

  logic             x_valid;
  logic             x;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             z_early;
  logic             z;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output x_valid, x, cfg_load, cfg_pattern, cfg_overlap, cnt_clr,
    input  z_early, z, match_cnt
  );

  modport slave (
    input  x_valid, x, cfg_load, cfg_pattern, cfg_overlap, cnt_clr,
    output z_early, z, match_cnt
  );

endinterface

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Ports:
//   i_clk  clock (rising edge)
//   i_rst  synchronous active-high reset
//   i_clr  clear to zero
//   i_inc  increment by one, holding at all-ones
//   o_cnt  registered count
module seq_det_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count register: reset, clear, then saturating increment.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with run-time programmable
// pattern and overlap mode.
// Ports:
//   clk  clock (rising edge)
//   rst  synchronous active-high reset
//   bus  seq_det_if slave: x_valid/x serial input, cfg_load/cfg_pattern/
//        cfg_overlap configuration, cnt_clr counter clear; outputs
//        z_early (combinational hit), z (registered hit pulse),
//        match_cnt (saturating hit count).
module seq_detector_param #(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = seq_det_pkg::PAT_1010,
  parameter bit               OVERLAP = 1'b1,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic      clk,
  input  logic      rst,
  seq_det_if.slave  bus
);

  import seq_det_pkg::*;

  localparam int unsigned       FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  // Once fill reaches PAT_W-1, the incoming bit completes a full window.
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  r_pat;
  ovl_mode_e         r_ovl;
  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              r_z;

  logic              w_take;
  logic              w_hit;
  logic [PAT_W-1:0]  w_hist_n;
  logic [FILL_W-1:0] w_fill_n;
  logic [PAT_W-1:0]  w_hist_nxt;
  logic [FILL_W-1:0] w_fill_nxt;

  // A bit is consumed only when valid and not displaced by a reconfiguration.
  assign w_take   = bus.x_valid & ~bus.cfg_load;
  assign w_hist_n = {r_hist[PAT_W-2:0], bus.x};
  assign w_fill_n = (r_fill == FILL_MAX) ? FILL_MAX : (r_fill + FILL_W'(1));
  // The fill gate keeps the zeroed reset history from matching an all-zero pattern.
  assign w_hit    = w_take & (r_fill >= FILL_ARM) & (w_hist_n == r_pat);

  // Next history/fill: reconfiguration restarts, valid bits shift in.
  always_comb begin
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    if (bus.cfg_load) begin
      w_hist_nxt = '0;
      w_fill_nxt = '0;
    end else if (w_take) begin
      w_hist_nxt = w_hist_n;
      if (w_hit && (r_ovl == NON_OVERLAP)) begin
        w_fill_nxt = '0;
      end else begin
        w_fill_nxt = w_fill_n;
      end
    end else begin
      w_hist_nxt = r_hist;
      w_fill_nxt = r_fill;
    end
  end

  // Detection state, configuration and registered hit pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat  <= PATTERN;
      r_ovl  <= ovl_mode_e'(OVERLAP);
      r_hist <= '0;
      r_fill <= '0;
      r_z    <= 1'b0;
    end else begin
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
      r_z    <= w_hit;
      if (bus.cfg_load) begin
        r_pat <= bus.cfg_pattern;
        r_ovl <= ovl_mode_e'(bus.cfg_overlap);
      end else begin
        r_pat <= r_pat;
        r_ovl <= r_ovl;
      end
    end
  end

  seq_det_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (bus.cnt_clr),
    .i_inc (w_hit),
    .o_cnt (bus.match_cnt)
  );

  assign bus.z_early = w_hit;
  assign bus.z       = r_z;

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised and directed check of seq_detector_param against a
// bit-queue reference model. Two instances share stimulus: one with the
// default 8-bit counter and one with a 2-bit counter to reach saturation.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       xv, xb, cl, co, cc;
  logic [3:0] cp;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: bits seen since the last restart, newest last.
  bit       mq[$];
  bit [3:0] m_pat;
  bit       m_ovl;
  bit       m_z;
  int       m_c8, m_c2;

  seq_det_if #(.PAT_W(4), .CNT_W(8)) bus8 ();
  seq_det_if #(.PAT_W(4), .CNT_W(2)) bus2 ();

  assign bus8.x_valid = xv;  assign bus2.x_valid = xv;
  assign bus8.x = xb;        assign bus2.x = xb;
  assign bus8.cfg_load = cl; assign bus2.cfg_load = cl;
  assign bus8.cfg_pattern = cp; assign bus2.cfg_pattern = cp;
  assign bus8.cfg_overlap = co; assign bus2.cfg_overlap = co;
  assign bus8.cnt_clr = cc;  assign bus2.cnt_clr = cc;

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(8))
    dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Hit if the last four valid bits (including the current one) equal the pattern.
  function automatic bit model_hit(bit v, bit b, bit l);
    bit w[$];
    int n;
    if (!v || l) return 1'b0;
    w = mq;
    w.push_back(b);
    n = w.size();
    if (n < 4) return 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (w[n-1-i] != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input bit r, input bit v, input bit b, input bit l,
                      input logic [3:0] p, input bit o, input bit c, input bit chk);
    bit h;
    rst = r; xv = v; xb = b; cl = l; cp = p; co = o; cc = c;
    #4;
    h = model_hit(v, b, l);
    if (chk) begin
      check_eq("z_early8", bus8.z_early, h);
      check_eq("z_early2", bus2.z_early, h);
      check_eq("z8", bus8.z, m_z);
      check_eq("z2", bus2.z, m_z);
      check_eq("cnt8", bus8.match_cnt, m_c8);
      check_eq("cnt2", bus2.match_cnt, m_c2);
    end
    @(posedge clk);
    if (r) begin
      m_pat = 4'b1010; m_ovl = 1'b1; mq.delete();
      m_z = 1'b0; m_c8 = 0; m_c2 = 0;
    end else begin
      m_z = h;
      if (c) begin
        m_c8 = 0; m_c2 = 0;
      end else if (h) begin
        if (m_c8 < 255) m_c8++;
        if (m_c2 < 3) m_c2++;
      end
      if (l) begin
        m_pat = p; m_ovl = o; mq.delete();
      end else if (v) begin
        mq.push_back(b);
        if (mq.size() > 8) void'(mq.pop_front());
        if (h && !m_ovl) mq.delete();
      end
    end
    #1;
  endtask

  task automatic send_bits(input logic [15:0] seq, input int n);
    logic [15:0] s;
    s = seq;
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, s[n-1-i], 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom), 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset (first cycle unchecked while registers are still unknown).
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    check_eq("rst_z", bus8.z, 0);
    check_eq("rst_cnt", bus8.match_cnt, 0);

    // Overlapping 1010 on 101010: hits on bits 4 and 6.
    send_bits(16'b101010, 6);
    check_eq("ovl_cnt", bus8.match_cnt, 2);

    // Non-overlapping: one hit on 101010, another after appending 10.
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0, 1'b1, 1'b1);
    send_bits(16'b101010, 6);
    check_eq("novl_cnt1", bus8.match_cnt, 1);
    send_bits(16'b10, 2);
    check_eq("novl_cnt2", bus8.match_cnt, 2);

    // Valid gaps with random x while invalid.
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(1, 3));
      send_bits(16'(i % 2 == 0), 1);
    end
    idle(1);
    check_eq("gap_cnt", bus8.match_cnt, 1);

    // Reprogram to 1111 with a valid bit in the same cycle (dropped).
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
    send_bits(16'b1111111, 7);
    check_eq("p1111_cnt8", bus8.match_cnt, 4);
    check_eq("p1111_sat2", bus2.match_cnt, 3);
    // Clear coincident with a hit: clear wins.
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    check_eq("clr_win", bus8.match_cnt, 0);
    send_bits(16'b11111, 5);
    check_eq("sat2_again", bus2.match_cnt, 3);

    // Reset mid-sequence discards the partial history.
    send_bits(16'b101, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    check_eq("post_rst_z", bus8.z, 0);
    send_bits(16'b0, 1);
    send_bits(16'b1010, 4);
    idle(1);
    check_eq("post_rst_cnt", bus8.match_cnt, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 99) < 70), 1'($urandom),
           1'($urandom_range(0, 99) < 3), 4'($urandom), 1'($urandom),
           1'($urandom_range(0, 99) < 3), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
